// File: rtl/snn_pkg.sv
// Shared constants and the image loader state encoding for the SNN front end.
// The classifier core reads NUM_PIXELS from here as its input-address maximum.
package snn_pkg;

   localparam int NUM_PIXELS = 784;
   localparam int IMG_BYTES  = NUM_PIXELS / 8;
   localparam int ADDR_W     = 10;

   typedef enum logic [1:0] {
      LD_IDLE = 2'd0,
      LD_LOAD = 2'd1,
      LD_FIRE = 2'd2,
      LD_WAIT = 2'd3
   } loader_state_t;

endpackage

// File: rtl/rx_byte_unpacker.sv
// Turns UART bytes into a stream of pixel bits, LSB first, one per cycle.
// A one-byte holding register absorbs a byte that arrives mid-unpack.
module rx_byte_unpacker (
   input  logic       clk,
   input  logic       rst,
   input  logic       flush,
   input  logic       load,
   input  logic [7:0] byte_in,
   output logic       bit_valid,
   output logic       bit_out,
   output logic       full
);

   logic [7:0] sh_q, sh_d;
   logic [2:0] cnt_q, cnt_d;
   logic       shv_q, shv_d;
   logic [7:0] hold_q, hold_d;
   logic       hold_v_q, hold_v_d;
   logic       last_bit;

   assign last_bit  = shv_q && (cnt_q == 3'd7);
   assign bit_valid = shv_q;
   assign bit_out   = sh_q[0];
   // Set only when neither the shifter nor the holding slot can take a byte.
   assign full      = shv_q && !last_bit && hold_v_q;

   always_comb begin
      sh_d     = sh_q;
      cnt_d    = cnt_q;
      shv_d    = shv_q;
      hold_d   = hold_q;
      hold_v_d = hold_v_q;
      if (flush) begin
         sh_d     = '0;
         cnt_d    = '0;
         shv_d    = 1'b0;
         hold_d   = '0;
         hold_v_d = 1'b0;
      end else if (!shv_q || last_bit) begin
         // Shifter frees this cycle: the older held byte goes first to keep order.
         cnt_d = '0;
         if (hold_v_q) begin
            sh_d     = hold_q;
            shv_d    = 1'b1;
            hold_d   = byte_in;
            hold_v_d = load;
         end else if (load) begin
            sh_d  = byte_in;
            shv_d = 1'b1;
         end else begin
            sh_d  = '0;
            shv_d = 1'b0;
         end
      end else begin
         sh_d  = {1'b0, sh_q[7:1]};
         cnt_d = cnt_q + 3'd1;
         if (load && !hold_v_q) begin
            hold_d   = byte_in;
            hold_v_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sh_q     <= '0;
         cnt_q    <= '0;
         shv_q    <= 1'b0;
         hold_q   <= '0;
         hold_v_q <= 1'b0;
      end else begin
         sh_q     <= sh_d;
         cnt_q    <= cnt_d;
         shv_q    <= shv_d;
         hold_q   <= hold_d;
         hold_v_q <= hold_v_d;
      end
   end

endmodule

// File: rtl/image_loader.sv
// Assembles one binary image from UART bytes into the classifier input RAM,
// fires start when complete, then blocks until the core reports done.
module image_loader #(
   parameter int NUM_PIXELS = snn_pkg::NUM_PIXELS,
   parameter int ADDR_W     = snn_pkg::ADDR_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            rx_data,
   input  logic                  rx_rdy,
   input  logic                  core_done,
   output logic                  ram_we,
   output logic [ADDR_W-1:0]     ram_waddr,
   output logic                  ram_wdata,
   output logic                  start,
   output logic                  busy,
   output logic                  overrun,
   output snn_pkg::loader_state_t dbg_state_o
);

   import snn_pkg::*;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

   loader_state_t     state_q;
   logic [ADDR_W-1:0] pix_addr_q;
   logic              busy_q;
   logic              start_q;
   logic              overrun_q;

   logic bit_valid, bit_out, full;
   logic last_write, load_en, drop;

   assign last_write = (state_q == LD_LOAD) && bit_valid && (pix_addr_q == LAST_ADDR);
   // A byte landing on the final pixel write would belong to no frame, so it is refused.
   assign load_en    = rx_rdy && ((state_q == LD_IDLE) || ((state_q == LD_LOAD) && !last_write));
   assign drop       = rx_rdy && !(load_en && !full);

   rx_byte_unpacker u_unpacker (
      .clk       (clk),
      .rst       (rst),
      .flush     (last_write),
      .load      (load_en),
      .byte_in   (rx_data),
      .bit_valid (bit_valid),
      .bit_out   (bit_out),
      .full      (full)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= LD_IDLE;
         pix_addr_q <= '0;
         busy_q     <= 1'b0;
         start_q    <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         start_q <= 1'b0;
         if (drop) overrun_q <= 1'b1;
         case (state_q)
            LD_IDLE: begin
               pix_addr_q <= '0;
               if (rx_rdy) begin
                  state_q <= LD_LOAD;
                  busy_q  <= 1'b1;
               end
            end
            LD_LOAD: begin
               if (bit_valid) begin
                  pix_addr_q <= pix_addr_q + ADDR_W'(1);
                  if (last_write) begin
                     state_q <= LD_FIRE;
                     start_q <= 1'b1;
                  end
               end
            end
            LD_FIRE: state_q <= LD_WAIT;
            LD_WAIT: begin
               if (core_done) begin
                  state_q    <= LD_IDLE;
                  busy_q     <= 1'b0;
                  pix_addr_q <= '0;
               end
            end
            default: state_q <= LD_IDLE;
         endcase
      end
   end

   assign ram_we      = bit_valid;
   assign ram_wdata   = bit_out;
   assign ram_waddr   = pix_addr_q;
   assign start       = start_q;
   assign busy        = busy_q;
   assign overrun     = overrun_q;
   assign dbg_state_o = state_q;

endmodule
